alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 134 +++++++++++++
 tb/tb_alu_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline (add/sub/AND/OR) with {N,Z,C,V} flags.
// Define ALU_STICKY_V_EN to enable the sticky overflow indicator sticky_v.
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags,
  input  logic             clear_sticky,
  output logic             sticky_v
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  alu_op_e          op_q, op_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;

  logic             s2_adv, in_fire;
  logic [WIDTH-1:0] b_eff, alu_res;
  logic [WIDTH:0]   sum;
  logic             carry, ovf;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_adv;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid_q;
  assign Result    = res_q;
  assign ALUFlags  = flags_q;

  // Subtraction reuses the adder as A + ~B + 1, so C=1 means no borrow.
  always_comb begin
    b_eff   = (op_q == OP_SUB) ? ~b_q : b_q;
    sum     = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_q == OP_SUB)};
    alu_res = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        carry   = sum[WIDTH];
        ovf     = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  alu_res = a_q & b_q;
      default: alu_res = a_q | b_q;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    flags_d    = flags_q;

    if (s2_adv) begin
      s1_valid_d = 1'b0;
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d   = alu_res;
        flags_d = {alu_res[WIDTH-1], (alu_res == '0), carry, ovf};
      end
    end

    // A same-cycle load overrides the drain so S1 refills without a bubble.
    if (in_fire) begin
      s1_valid_d = 1'b1;
      a_d        = A;
      b_d        = B;
      op_d       = alu_op_e'(ALUControl);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
    end
  end

`ifdef ALU_STICKY_V_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (s2_valid_q && out_ready && flags_q[0]) sticky_d = 1'b1;
    if (clear_sticky) sticky_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  assign sticky_v = sticky_q;
`else
  logic unused_clear_sticky;
  assign unused_clear_sticky = clear_sticky;
  assign sticky_v            = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=4): queue-based reference model plus directed cases.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A, B;
  logic [1:0] ALUControl;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] Result;
  logic [3:0] ALUFlags;
  logic       clear_sticky;
  logic       sticky_v;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  typedef struct {
    int         stamp;
    logic [7:0] exp;
  } ent_t;

  ent_t q[$];
  logic sticky_exp = 1'b0;

  alu_pipe #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .ALUControl  (ALUControl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Result      (Result),
    .ALUFlags    (ALUFlags),
    .clear_sticky(clear_sticky),
    .sticky_v    (sticky_v)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Returns {Result[3:0], N, Z, C, V} from plain integer arithmetic.
  function automatic logic [7:0] ref_alu(input int a, input int b, input int op);
    int r, full, sa, sb, sr;
    logic c, v;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin full = a + b; r = full % 16; c = (full >= 16); sr = sa + sb; v = (sr > 7) || (sr < -8); end
      1: begin full = a - b + 16; r = full % 16; c = (a >= b); sr = sa - sb; v = (sr > 7) || (sr < -8); end
      2: r = a & b;
      default: r = a | b;
    endcase
    return {r[3:0], (r >= 8), (r == 0), c, v};
  endfunction

  always @(negedge clk) begin : monitor
    int   n;
    logic exp_ov;
    if (reset) begin
      q.delete();
      sticky_exp = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
    end else begin
      n      = q.size();
      exp_ov = (n > 0) && (q[0].stamp < cyc);
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, (n < 2) || out_ready);
      if (out_valid && n > 0) begin
        chk("result", Result, q[0].exp[7:4]);
        chk("flags", ALUFlags, q[0].exp[3:0]);
      end
      chk("sticky_v", sticky_v, sticky_exp);
`ifdef ALU_STICKY_V_EN
      if (clear_sticky) sticky_exp = 1'b0;
      else if (out_valid && out_ready && n > 0 && q[0].exp[0]) sticky_exp = 1'b1;
`endif
      if (out_valid && out_ready && n > 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back('{stamp: cyc + 1, exp: ref_alu(int'(A), int'(B), int'(ALUControl))});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    logic acc;
    in_valid   = 1'b1;
    A          = a;
    B          = b;
    ALUControl = op;
    acc        = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    chk("send_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [3:0] res, input logic [3:0] fl, output int lat);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({name, "_seen"}, lat >= 0, 1);
    if (lat >= 0) begin
      chk({name, "_result"}, Result, res);
      chk({name, "_flags"}, ALUFlags, fl);
    end
    step();
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 30 && q.size() != 0; k++) step();
    chk(name, q.size(), 0);
  endtask

  logic [3:0] ba[4], bb[4];
  logic [1:0] bop[4];

  initial begin : stimulus
    int lat, idx, cycles;
    logic acc;
    reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; ALUControl = '0;
    out_ready = 1'b1; clear_sticky = 1'b0;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", Result, 0);
    chk("reset_flags", ALUFlags, 0);
    chk("reset_sticky", sticky_v, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    chk("model_or",  ref_alu(5, 2, 3), 8'b0111_0000);
    chk("model_sub", ref_alu(2, 5, 1), 8'b1101_1000);
    chk("model_ovf", ref_alu(7, 1, 0), 8'b1000_1001);
    chk("model_wrap", ref_alu(15, 1, 0), 8'b0000_0110);

    send(4'b0101, 4'b0010, 2'b11);
    expect_out("or", 4'b0111, 4'b0000, lat);
    chk("latency", lat, 1);
    send(4'b0010, 4'b0101, 2'b10);
    expect_out("and", 4'b0000, 4'b0100, lat);
    send(4'b0010, 4'b0101, 2'b01);
    expect_out("sub", 4'b1101, 4'b1000, lat);
    send(4'b1111, 4'b0001, 2'b00);
    expect_out("carry", 4'b0000, 4'b0110, lat);

    send(4'b0111, 4'b0001, 2'b00);
    expect_out("ovf", 4'b1000, 4'b1001, lat);
`ifdef ALU_STICKY_V_EN
    chk("sticky_set", sticky_v, 1);
`else
    chk("sticky_set", sticky_v, 0);
`endif
    clear_sticky = 1'b1;
    step();
    clear_sticky = 1'b0;
    chk("sticky_cleared", sticky_v, 0);

    for (int i = 0; i < 4; i++) begin
      ba[i]  = 4'($urandom_range(0, 15));
      bb[i]  = 4'($urandom_range(0, 15));
      bop[i] = 2'($urandom_range(0, 3));
    end
    out_ready = 1'b0; idx = 0; cycles = 0;
    in_valid = 1'b1; A = ba[0]; B = bb[0]; ALUControl = bop[0];
    while (idx < 4 && cycles < 40) begin
      @(negedge clk);
      acc = in_ready;
      if (cycles == 2) chk("bp_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
      if (acc) idx++;
      cycles++;
      if (cycles == 3) begin
        chk("bp_accepted_before_release", idx, 2);
        out_ready = 1'b1;
      end
      if (idx < 4) begin A = ba[idx]; B = bb[idx]; ALUControl = bop[idx]; end
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", idx, 4);
    drain("bp_drained");

    out_ready = 1'b0;
    send(4'd1, 4'd2, 2'b00);
    send(4'd3, 4'd4, 2'b01);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", Result, 0);
    chk("midrst_flags", ALUFlags, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sticky", sticky_v, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_reset_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    send(4'd6, 4'd3, 2'b01);
    expect_out("first_after_reset", 4'd3, 4'b0010, lat);

    for (int i = 0; i < 400; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      A            = 4'($urandom_range(0, 15));
      B            = 4'($urandom_range(0, 15));
      ALUControl   = 2'($urandom_range(0, 3));
      out_ready    = ($urandom_range(0, 2) != 0);
      clear_sticky = ($urandom_range(0, 7) == 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; clear_sticky = 1'b0;
    drain("random_drained");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d passed so far)", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
